// File: rtl/mtimer_pkg.sv
// Shared register-map offsets and byte-merge helper for the machine timer.
package mtimer_pkg;

  localparam logic [15:0] OFS_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] OFS_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] OFS_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] OFS_MTIME_HI    = 16'hBFFC;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wmask);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[i*8 +: 8] = wmask[i] ? wdata[i*8 +: 8] : old_word[i*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/mtimer_reg64.sv
// 64-bit register with byte-masked half writes; a write takes priority over increment.
module mtimer_reg64
  import mtimer_pkg::*;
#(
  parameter logic [63:0] RST_VAL = '0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        we,
  input  logic        hi_sel,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  input  logic        inc,
  output logic [63:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= RST_VAL;
    end else if (we) begin
      if (hi_sel)
        q[63:32] <= merge_bytes(q[63:32], wdata, wmask);
      else
        q[31:0]  <= merge_bytes(q[31:0], wdata, wmask);
    end else if (inc) begin
      q <= q + 64'd1;
    end
  end

endmodule

// File: rtl/mtimer.sv
// RISC-V machine timer (mtime/mtimecmp) on the core data bus.
// Optional MTIME_SNAPSHOT_EN: a read of mtime lo latches mtime hi for a tear-free 64-bit read.
module mtimer
  import mtimer_pkg::*;
#(
  parameter logic [31:0] BASE    = 32'h4400_0000,
  parameter int unsigned DIVIDER = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_valid,
  input  logic        mem_write,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        irq_timer
);

  logic        hit;
  logic [15:0] ofs;
  logic        sel_mtime;
  logic        sel_cmp;
  logic        wr_mtime;
  logic        wr_cmp;
  logic        rd_mtime_lo;
  logic        tick;
  logic [15:0] pre_cnt;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] mtime_hi_rd;
  logic [31:0] rdata_next;
  logic        unused_addr;

  assign unused_addr = ^mem_addr[1:0];

  assign hit         = mem_valid && (mem_addr[31:16] == BASE[31:16]);
  assign ofs         = {mem_addr[15:2], 2'b00};
  assign sel_mtime   = (ofs == OFS_MTIME_LO) || (ofs == OFS_MTIME_HI);
  assign sel_cmp     = (ofs == OFS_MTIMECMP_LO) || (ofs == OFS_MTIMECMP_HI);
  assign wr_mtime    = hit && mem_write && sel_mtime;
  assign wr_cmp      = hit && mem_write && sel_cmp;
  assign rd_mtime_lo = hit && !mem_write && (ofs == OFS_MTIME_LO);
  assign tick        = (pre_cnt == 16'(DIVIDER - 1));

  // Prescaler restarts its period on any mtime write so software sees a full tick
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      pre_cnt <= '0;
    else if (wr_mtime || tick)
      pre_cnt <= '0;
    else
      pre_cnt <= pre_cnt + 16'd1;
  end

  mtimer_reg64 #(.RST_VAL(64'h0)) u_mtime (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_mtime),
    .hi_sel(ofs == OFS_MTIME_HI),
    .wmask (mem_wmask),
    .wdata (mem_wdata),
    .inc   (tick),
    .q     (mtime)
  );

  mtimer_reg64 #(.RST_VAL(64'hFFFF_FFFF_FFFF_FFFF)) u_mtimecmp (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_cmp),
    .hi_sel(ofs == OFS_MTIMECMP_HI),
    .wmask (mem_wmask),
    .wdata (mem_wdata),
    .inc   (1'b0),
    .q     (mtimecmp)
  );

`ifdef MTIME_SNAPSHOT_EN
  logic [31:0] mtime_hi_shadow;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      mtime_hi_shadow <= '0;
    else if (rd_mtime_lo)
      mtime_hi_shadow <= mtime[63:32];
  end

  assign mtime_hi_rd = mtime_hi_shadow;
`else
  logic unused_rd_lo;

  assign unused_rd_lo = rd_mtime_lo;
  assign mtime_hi_rd  = mtime[63:32];
`endif

  always_comb begin
    rdata_next = '0;
    if (hit && !mem_write) begin
      case (ofs)
        OFS_MTIMECMP_LO: rdata_next = mtimecmp[31:0];
        OFS_MTIMECMP_HI: rdata_next = mtimecmp[63:32];
        OFS_MTIME_LO:    rdata_next = mtime[31:0];
        OFS_MTIME_HI:    rdata_next = mtime_hi_rd;
        default:         rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_rdata <= '0;
      irq_timer <= 1'b0;
    end else begin
      mem_rdata <= rdata_next;
      irq_timer <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_mtimer.sv
// Directed bench for mtimer: DIVIDER=1 and DIVIDER=4 instances share one bus.
module tb_mtimer;

  localparam logic [31:0] A_CMP_LO   = 32'h4400_4000;
  localparam logic [31:0] A_CMP_HI   = 32'h4400_4004;
  localparam logic [31:0] A_MTIME_LO = 32'h4400_BFF8;
  localparam logic [31:0] A_MTIME_HI = 32'h4400_BFFC;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_valid;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [31:0] rdata1, rdata4;
  logic        irq1, irq4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mtimer #(.BASE(32'h4400_0000), .DIVIDER(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .mem_rdata(rdata1), .irq_timer(irq1)
  );

  mtimer #(.BASE(32'h4400_0000), .DIVIDER(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .mem_rdata(rdata4), .irq_timer(irq4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the request is taken at the next posedge.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mem_valid = 1'b1; mem_write = 1'b1; mem_addr = a; mem_wdata = d; mem_wmask = m;
    @(negedge clk);
    mem_valid = 1'b0; mem_write = 1'b0; mem_wmask = 4'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d1, output logic [31:0] d4);
    mem_valid = 1'b1; mem_write = 1'b0; mem_addr = a;
    @(negedge clk);
    d1 = rdata1; d4 = rdata4;
    mem_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] r1, r4;
    logic [31:0] snap_exp;
    rstn = 1'b0; mem_valid = 1'b0; mem_write = 1'b0;
    mem_wmask = 4'h0; mem_wdata = '0; mem_addr = '0;

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_rdata", rdata1, 32'h0);
    chk("rst_irq", {31'h0, irq1}, 32'h0);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    bus_rd(A_MTIME_LO, r1, r4);
    chk("mtime_10clk", r1, 32'd10);
    chk("mtime_div4_10clk", r4, 32'd2);
    bus_rd(A_CMP_LO, r1, r4);
    chk("cmp_lo_rst", r1, 32'hFFFF_FFFF);
    bus_rd(A_CMP_HI, r1, r4);
    chk("cmp_hi_rst", r1, 32'hFFFF_FFFF);
    chk("irq_idle", {31'h0, irq1}, 32'h0);

    // Compare: mtime reaches 50 ten clocks after the lo=40 write
    bus_wr(A_CMP_HI, 32'h0, 4'hF);
    chk("wr_rdata_zero", rdata1, 32'h0);
    bus_wr(A_CMP_LO, 32'd50, 4'hF);
    bus_wr(A_MTIME_HI, 32'h0, 4'hF);
    bus_wr(A_MTIME_LO, 32'd40, 4'hF);
    repeat (10) @(negedge clk);
    chk("irq_at_mtime50", {31'h0, irq1}, 32'h0);
    @(negedge clk);
    chk("irq_rise", {31'h0, irq1}, 32'h1);
    repeat (3) @(negedge clk);
    chk("irq_level", {31'h0, irq1}, 32'h1);
    bus_wr(A_CMP_HI, 32'h1, 4'hF);
    chk("irq_hold_wr", {31'h0, irq1}, 32'h1);
    @(negedge clk);
    chk("irq_drop", {31'h0, irq1}, 32'h0);

    // Byte mask and unmapped offsets
    bus_wr(A_CMP_LO, 32'hFFFF_FFFF, 4'hF);
    bus_wr(A_CMP_LO, 32'hAABB_CCDD, 4'b0101);
    bus_rd(A_CMP_LO, r1, r4);
    chk("bytemask", r1, 32'hFFBB_FFDD);
    bus_wr(32'h4400_4008, 32'h1234_5678, 4'hF);
    bus_rd(A_CMP_LO, r1, r4);
    chk("unmapped_wr_lo", r1, 32'hFFBB_FFDD);
    bus_rd(A_CMP_HI, r1, r4);
    chk("unmapped_wr_hi", r1, 32'h1);
    bus_rd(32'h4400_4008, r1, r4);
    chk("unmapped_rd", r1, 32'h0);
    bus_rd(32'h4500_4000, r1, r4);
    chk("other_base_rd", r1, 32'h0);

    // 64-bit wrap with carry
    bus_wr(A_MTIME_HI, 32'hFFFF_FFFF, 4'hF);
    bus_wr(A_MTIME_LO, 32'hFFFF_FFFE, 4'hF);
    bus_rd(A_MTIME_LO, r1, r4);
    chk("wrap_lo0", r1, 32'hFFFF_FFFE);
    bus_rd(A_MTIME_HI, r1, r4);
    chk("wrap_hi0", r1, 32'hFFFF_FFFF);
    bus_rd(A_MTIME_LO, r1, r4);
    chk("wrap_lo2", r1, 32'h0);
    bus_rd(A_MTIME_HI, r1, r4);
    chk("wrap_hi2", r1, 32'h0);

    // Write beats a coinciding tick; DIVIDER=4 period timing
    bus_wr(A_MTIME_LO, 32'h100, 4'hF);
    bus_rd(A_MTIME_LO, r1, r4);
    chk("wr_over_tick", r1, 32'h100);
    chk("div4_p1", r4, 32'h100);
    repeat (2) @(negedge clk);
    bus_rd(A_MTIME_LO, r1, r4);
    chk("div4_p4", r4, 32'h100);
    bus_rd(A_MTIME_LO, r1, r4);
    chk("div4_p5", r4, 32'h101);
    @(negedge clk);
    bus_wr(A_MTIME_LO, 32'h200, 4'hF);
    bus_rd(A_MTIME_LO, r1, r4);
    chk("div4_restart_p1", r4, 32'h200);
    repeat (2) @(negedge clk);
    bus_rd(A_MTIME_LO, r1, r4);
    chk("div4_restart_p4", r4, 32'h200);
    bus_rd(A_MTIME_LO, r1, r4);
    chk("div4_restart_p5", r4, 32'h201);

    // Snapshot of mtime hi on a lo read
    bus_wr(A_MTIME_HI, 32'h0, 4'hF);
    bus_wr(A_MTIME_LO, 32'hFFFF_FFFF, 4'hF);
    bus_rd(A_MTIME_LO, r1, r4);
    chk("snap_lo", r1, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    bus_rd(A_MTIME_HI, r1, r4);
`ifdef MTIME_SNAPSHOT_EN
    snap_exp = 32'h0;
`else
    snap_exp = 32'h1;
`endif
    chk("snap_hi", r1, snap_exp);

    // Asynchronous reset between clock edges
    bus_rd(A_CMP_HI, r1, r4);
    chk("pre_areset_rd", r1, 32'h1);
    #2 rstn = 1'b0;
    #1;
    chk("areset_rdata", rdata1, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    bus_rd(A_CMP_LO, r1, r4);
    chk("areset_cmp_lo", r1, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
